// File: rtl/line_mem_ctrl.sv
// Line refill controller: arbitrates instruction/data line requests and moves
// each 256-bit line as eight 32-bit req/ack beats on the external memory bus.
module line_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int BEAT_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                rom_read_op,
   input  logic [ADDR_W-1:0]   rom_addr,
   output logic [8*BEAT_W-1:0] rom_data,
   output logic                rom_ready,
   input  logic                ram_read_op,
   input  logic                ram_write_op,
   input  logic [ADDR_W-1:0]   ram_addr,
   input  logic [8*BEAT_W-1:0] ram_wdata,
   output logic [8*BEAT_W-1:0] ram_rdata,
   output logic                ram_ready,
   output logic                ext_req,
   output logic                ext_we,
   output logic [ADDR_W-1:0]   ext_addr,
   output logic [BEAT_W-1:0]   ext_wdata,
   input  logic [BEAT_W-1:0]   ext_rdata,
   input  logic                ext_ack
);
   localparam int LINE_W = 8*BEAT_W;
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(32'h1F);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                we_q, we_d;
   logic                src_ram_q, src_ram_d;
   logic                last_ram_q, last_ram_d;
   logic [LINE_W-1:0]   wline_q, wline_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]   rom_data_q, rom_data_d;
   logic [LINE_W-1:0]   ram_rdata_q, ram_rdata_d;
   logic                rom_ready_q, rom_ready_d;
   logic                ram_ready_q, ram_ready_d;
   logic                take_rom, take_ram;

   // A pending rom request beats ram right after ram was served, so a busy
   // data side cannot starve instruction fetch.
   assign take_rom = rom_read_op && (last_ram_q || !(ram_read_op || ram_write_op));
   assign take_ram = !take_rom && (ram_read_op || ram_write_op);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      we_d        = we_q;
      src_ram_d   = src_ram_q;
      last_ram_d  = last_ram_q;
      wline_d     = wline_q;
      line_d      = line_q;
      rom_data_d  = rom_data_q;
      ram_rdata_d = ram_rdata_q;
      rom_ready_d = 1'b0;
      ram_ready_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (take_rom) begin
               state_d   = XFER;
               cnt_d     = 3'd0;
               base_d    = rom_addr & ~LINE_MASK;
               we_d      = 1'b0;
               src_ram_d = 1'b0;
            end else if (take_ram) begin
               state_d   = XFER;
               cnt_d     = 3'd0;
               base_d    = ram_addr & ~LINE_MASK;
               we_d      = ram_write_op;
               src_ram_d = 1'b1;
               wline_d   = ram_wdata;
            end
         end
         XFER: begin
            if (ext_ack) begin
               if (!we_q) line_d[32'(cnt_q)*BEAT_W +: BEAT_W] = ext_rdata;
               cnt_d = cnt_q + 3'd1;
               // Ready and line output are registered on the last ack so both
               // appear together in the DONE cycle.
               if (cnt_q == 3'd7) begin
                  state_d    = DONE;
                  last_ram_d = src_ram_q;
                  if (src_ram_q) ram_ready_d = 1'b1;
                  else           rom_ready_d = 1'b1;
                  if (!we_q) begin
                     if (src_ram_q) ram_rdata_d = line_d;
                     else           rom_data_d  = line_d;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         base_q      <= '0;
         we_q        <= 1'b0;
         src_ram_q   <= 1'b0;
         last_ram_q  <= 1'b0;
         wline_q     <= '0;
         line_q      <= '0;
         rom_data_q  <= '0;
         ram_rdata_q <= '0;
         rom_ready_q <= 1'b0;
         ram_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         we_q        <= we_d;
         src_ram_q   <= src_ram_d;
         last_ram_q  <= last_ram_d;
         wline_q     <= wline_d;
         line_q      <= line_d;
         rom_data_q  <= rom_data_d;
         ram_rdata_q <= ram_rdata_d;
         rom_ready_q <= rom_ready_d;
         ram_ready_q <= ram_ready_d;
      end
   end

   assign ext_req   = (state_q == XFER);
   assign ext_we    = ext_req && we_q;
   assign ext_addr  = base_q + ADDR_W'({cnt_q, 2'b00});
   assign ext_wdata = wline_q[32'(cnt_q)*BEAT_W +: BEAT_W];
   assign rom_data  = rom_data_q;
   assign ram_rdata = ram_rdata_q;
   assign rom_ready = rom_ready_q;
   assign ram_ready = ram_ready_q;
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed + random bench for line_mem_ctrl with a word-addressed reference
// memory and a latency-programmable external memory responder.
module tb_line_mem_ctrl;
   logic         CLK = 1'b0;
   logic         RST;
   logic         rom_read_op, ram_read_op, ram_write_op;
   logic [31:0]  rom_addr, ram_addr;
   logic [255:0] ram_wdata, rom_data, ram_rdata;
   logic         rom_ready, ram_ready;
   logic         ext_req, ext_we, ext_ack;
   logic [31:0]  ext_addr, ext_wdata, ext_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] a;
      logic        we;
      logic [31:0] d;
   } beat_t;

   beat_t        beats[$];
   logic [31:0]  mem     [logic [31:0]];
   logic [31:0]  ref_mem [logic [31:0]];
   int           lat_cfg = 0;
   int           wait_n  = 0;
   logic [64:0]  held;
   logic [255:0] exp_rom, exp_ram;
   bit           exp_last_ram;

   line_mem_ctrl #(.ADDR_W(32), .BEAT_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .rom_read_op(rom_read_op), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
      .ram_read_op(ram_read_op), .ram_write_op(ram_write_op), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_ack(ext_ack)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // External memory: acks each beat after lat_cfg wait cycles; beat fields
   // must not move while a beat is waiting.
   always @(negedge CLK) begin
      if (RST || !ext_req) begin
         ext_ack   = 1'b0;
         ext_rdata = '0;
         wait_n    = 0;
      end else begin
         if (wait_n > 0) chk("beat_hold", 256'({ext_addr, ext_we, ext_wdata}), 256'(held));
         if (wait_n >= lat_cfg) begin
            ext_ack   = 1'b1;
            ext_rdata = mem.exists(ext_addr) ? mem[ext_addr] : init_word(ext_addr);
            if (ext_we) mem[ext_addr] = ext_wdata;
            beats.push_back('{a: ext_addr, we: ext_we, d: ext_wdata});
            wait_n = 0;
         end else begin
            ext_ack = 1'b0;
            if (wait_n == 0) held = {ext_addr, ext_we, ext_wdata};
            wait_n++;
         end
      end
   end

   task automatic drop_reqs();
      rom_read_op  = 1'b0;
      ram_read_op  = 1'b0;
      ram_write_op = 1'b0;
   endtask

   // kind: 0 rom read, 1 ram read, 2 ram write, 3 ram read+write
   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [255:0] wl,
                          input int lat, input int drop_at, input string tag);
      logic [31:0]  base;
      logic [255:0] exp_line;
      bit           wr, is_rom, other;
      int           got_c;
      base   = addr & 32'hFFFF_FFE0;
      wr     = (kind >= 2);
      is_rom = (kind == 0);
      for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = ref_rd(base + 32'(4*k));
      @(negedge CLK);
      beats.delete();
      lat_cfg      = lat;
      rom_addr     = addr;
      ram_addr     = addr;
      ram_wdata    = wl;
      rom_read_op  = is_rom;
      ram_read_op  = (kind == 1 || kind == 3);
      ram_write_op = wr;
      got_c = -1;
      other = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge CLK);
         if (c == drop_at) drop_reqs();
         if (is_rom ? ram_ready : rom_ready) other = 1'b1;
         if (is_rom ? rom_ready : ram_ready) begin
            got_c = c;
            break;
         end
      end
      drop_reqs();
      chk($sformatf("%s ready_cycle", tag), 256'(got_c), 256'(1 + 8*(lat+1)));
      chk($sformatf("%s wrong_port_ready", tag), 256'(other), 256'(0));
      chk($sformatf("%s beat_count", tag), 256'(beats.size()), 256'(8));
      for (int k = 0; k < 8 && k < beats.size(); k++) begin
         chk($sformatf("%s beat%0d addr", tag, k), 256'(beats[k].a), 256'(base + 32'(4*k)));
         chk($sformatf("%s beat%0d we", tag, k), 256'(beats[k].we), 256'(wr));
         if (wr) chk($sformatf("%s beat%0d wdata", tag, k), 256'(beats[k].d), 256'(wl[32*k +: 32]));
      end
      if (wr) begin
         for (int k = 0; k < 8; k++) ref_mem[base + 32'(4*k)] = wl[32*k +: 32];
      end else if (is_rom) exp_rom = exp_line;
      else exp_ram = exp_line;
      exp_last_ram = !is_rom;
      chk($sformatf("%s rom_data", tag), rom_data, exp_rom);
      chk($sformatf("%s ram_rdata", tag), ram_rdata, exp_ram);
      @(negedge CLK);
      chk($sformatf("%s ready_pulse_len", tag), 256'({rom_ready, ram_ready}), 256'(0));
      chk($sformatf("%s idle_after", tag), 256'(ext_req), 256'(0));
      $display("txn %s kind=%0d addr=%h lat=%0d ready_cycle=%0d", tag, kind, addr, lat, got_c);
   endtask

   task automatic chk_all_zero(input string tag);
      chk($sformatf("%s ext_req", tag), 256'(ext_req), 256'(0));
      chk($sformatf("%s ext_we", tag), 256'(ext_we), 256'(0));
      chk($sformatf("%s ext_addr", tag), 256'(ext_addr), 256'(0));
      chk($sformatf("%s ext_wdata", tag), 256'(ext_wdata), 256'(0));
      chk($sformatf("%s rom_data", tag), rom_data, 256'(0));
      chk($sformatf("%s ram_rdata", tag), ram_rdata, 256'(0));
      chk($sformatf("%s readies", tag), 256'({rom_ready, ram_ready}), 256'(0));
   endtask

   initial begin
      logic [255:0] wl, rom_line, ram_line;
      logic [1:0]   exp_which;
      int           n;
      logic [31:0]  ra;
      RST = 1'b1;
      drop_reqs();
      rom_addr = '0; ram_addr = '0; ram_wdata = '0;
      ext_ack = 1'b0; ext_rdata = '0;
      exp_rom = '0; exp_ram = '0; exp_last_ram = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mem[32'h1020 + 32'(4*k)]     = 32'h1111_1111 * k + k;
         ref_mem[32'h1020 + 32'(4*k)] = 32'h1111_1111 * k + k;
      end
      repeat (2) @(negedge CLK);
      chk_all_zero("reset");
      RST = 1'b0;
      @(negedge CLK);
      chk_all_zero("post_reset");

      run_txn(0, 32'h0000_1024, '0, 0, -1, "rom_zero_wait");
      run_txn(1, 32'h0000_0300, '0, 1, -1, "ram_read");
      for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'hA0 + k;
      run_txn(2, 32'h0000_0200, wl, 2, -1, "ram_write");
      for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
      run_txn(3, 32'h0000_0240, wl, 0, -1, "ram_rd_wr");
      run_txn(0, 32'h0000_1040, '0, 0, 3, "rom_drop");

      // Both sides held: service must alternate, starting per last source.
      for (int k = 0; k < 8; k++) begin
         rom_line[32*k +: 32] = ref_rd(32'h200 + 32'(4*k));
         ram_line[32*k +: 32] = ref_rd(32'h240 + 32'(4*k));
      end
      exp_which = exp_last_ram ? 2'b10 : 2'b01;
      @(negedge CLK);
      lat_cfg = 0;
      rom_addr = 32'h200; ram_addr = 32'h240;
      rom_read_op = 1'b1; ram_read_op = 1'b1;
      n = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge CLK);
         if (rom_ready || ram_ready) begin
            chk($sformatf("alt%0d port", n), 256'({rom_ready, ram_ready}), 256'(exp_which));
            chk($sformatf("alt%0d cycle", n), 256'(c), 256'(9 + 10*n));
            if (exp_which == 2'b10) exp_rom = rom_line;
            else                    exp_ram = ram_line;
            chk($sformatf("alt%0d rom_data", n), rom_data, exp_rom);
            chk($sformatf("alt%0d ram_rdata", n), ram_rdata, exp_ram);
            $display("txn alt%0d ready=%b cycle=%0d", n, {rom_ready, ram_ready}, c);
            exp_last_ram = (exp_which == 2'b01);
            exp_which = ~exp_which;
            n++;
            if (n == 3) break;
         end
      end
      drop_reqs();
      chk("alt pulses", 256'(n), 256'(3));

      // Async reset in the middle of beat 4 of a rom read.
      @(negedge CLK);
      @(negedge CLK);
      lat_cfg = 0;
      rom_addr = 32'h1060;
      rom_read_op = 1'b1;
      repeat (5) @(negedge CLK);
      chk("rst_mid beat4 addr", 256'(ext_addr), 256'(32'h1070));
      chk("rst_mid beat4 req", 256'(ext_req), 256'(1));
      #2 RST = 1'b1;
      #1 chk_all_zero("rst_mid");
      $display("txn rst_mid ext_req=%b", ext_req);
      drop_reqs();
      @(negedge CLK);
      RST = 1'b0;
      exp_rom = '0; exp_ram = '0; exp_last_ram = 1'b0;
      run_txn(0, 32'h0000_1064, '0, 0, -1, "rom_after_rst");

      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 4))
            0:       ra = 32'h0000_0200;
            1:       ra = 32'h0000_0240;
            2:       ra = 32'h0000_1020;
            3:       ra = 32'h0000_1064;
            default: ra = $urandom;
         endcase
         ra = ra | 32'($urandom_range(0, 31));
         for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
         run_txn($urandom_range(0, 3), ra, wl, $urandom_range(0, 3), -1, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
